cla_adder32_pipe: RTL and testbench

//  2-stage pipelined 32-bit add/subtract unit for the EX stage of the five-stage MIPS core.

---
 rtl/cla_pkg.sv | 17 +
 rtl/cla_group4.sv | 28 ++
 rtl/cla_adder32_pipe.sv | 135 +++++++++++++
 tb/tb_cla_adder32_pipe.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared sizing and stage-1 payload type for the pipelined CLA adder.
// Imported by cla_group4 and cla_adder32_pipe.
package cla_pkg;

  localparam int CLA_WIDTH   = 32;
  localparam int CLA_GROUP   = 4;
  localparam int CLA_NGROUPS = CLA_WIDTH / CLA_GROUP;

  typedef struct packed {
    logic [CLA_WIDTH-1:0]   p;
    logic [CLA_WIDTH-1:0]   g;
    logic [CLA_NGROUPS-1:0] G;
    logic [CLA_NGROUPS-1:0] P;
    logic                   c0;
  } s1_t;

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group cell (combinational).
// in: g,p[3:0], ci; out: internal carries c[3:1], group G/P.
module cla_group4 (
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       ci,
  output logic [3:1] c,
  output logic       G,
  output logic       P
);

  assign c[1] = g[0]
              | (p[0] & ci);
  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & ci);
  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);

  assign G = g[3]
           | (p[3] & g[2])
           | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
  assign P = &p;

endmodule

// File: rtl/cla_adder32_pipe.sv
// 2-stage pipelined 32-bit CLA add/sub with valid/ready on both sides.
// in: a,b,cin,sub,in_valid,out_ready; out: sum,cout,ovf,zero,out_valid,in_ready.
module cla_adder32_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG = WIDTH / GROUP;

  logic s1_valid;
  logic adv2;

  assign adv2     = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | adv2;

  // ---------------- stage 1 ----------------
  logic [WIDTH-1:0] bb;
  logic [WIDTH-1:0] p1;
  logic [WIDTH-1:0] g1;
  logic [NG-1:0]    gg1;
  logic [NG-1:0]    pp1;
  logic [3*NG-1:0]  c1_unused;
  s1_t              s1_d;
  s1_t              s1_q;

  assign bb = sub ? ~b : b;
  assign p1 = a ^ bb;
  assign g1 = a & bb;

  for (genvar k = 0; k < NG; k++) begin : g_s1
    cla_group4 u_grp (
      .g  (g1[GROUP*k +: 4]),
      .p  (p1[GROUP*k +: 4]),
      .ci (1'b0),
      .c  (c1_unused[3*k +: 3]),
      .G  (gg1[k]),
      .P  (pp1[k])
    );
  end

  always_comb begin
    s1_d    = '0;
    s1_d.p  = p1;
    s1_d.g  = g1;
    s1_d.G  = gg1;
    s1_d.P  = pp1;
    s1_d.c0 = sub | cin;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  // ---------------- stage 2 ----------------
  // Group carries are sum-of-products over all lower
  // groups, so no carry ripples from group to group.
  logic [NG:0]      cg;
  logic [WIDTH-1:0] c2;
  logic [2*NG-1:0]  gp2_unused;
  logic [WIDTH-1:0] sum_d;

  always_comb begin
    logic t_acc;
    logic t_pp;
    t_acc = 1'b0;
    t_pp  = 1'b0;
    cg    = '0;
    cg[0] = s1_q.c0;
    for (int k = 0; k < NG; k++) begin
      t_acc = s1_q.G[k];
      t_pp  = s1_q.P[k];
      for (int j = k - 1; j >= 0; j--) begin
        t_acc = t_acc | (t_pp & s1_q.G[j]);
        t_pp  = t_pp & s1_q.P[j];
      end
      cg[k+1] = t_acc | (t_pp & s1_q.c0);
    end
  end

  for (genvar k = 0; k < NG; k++) begin : g_s2
    assign c2[GROUP*k] = cg[k];
    cla_group4 u_grp (
      .g  (s1_q.g[GROUP*k +: 4]),
      .p  (s1_q.p[GROUP*k +: 4]),
      .ci (cg[k]),
      .c  (c2[GROUP*k+1 +: 3]),
      .G  (gp2_unused[2*k]),
      .P  (gp2_unused[2*k+1])
    );
  end

  assign sum_d = s1_q.p ^ c2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum  <= sum_d;
        cout <= cg[NG];
        ovf  <= cg[NG] ^ c2[WIDTH-1];
        zero <= ~|sum_d;
      end
    end
  end

endmodule

// File: tb/tb_cla_adder32_pipe.sv
// Self-checking bench for cla_adder32_pipe.
// Random and directed ops against an arithmetic reference queue.
module tb_cla_adder32_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;

  always #5 clk = ~clk;

  cla_adder32_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  int          n_chk = 0;
  int          n_err = 0;
  int          acc_cnt = 0;
  logic [34:0] exq[$];
  logic        hold_q = 1'b0;
  logic [34:0] hold_v = '0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // {sum, cout, ovf, zero} from plain 33-bit arithmetic
  function automatic logic [34:0] ref_op(
    input logic [31:0] ra, input logic [31:0] rb,
    input logic rcin, input logic rsub);
    logic [31:0] ob;
    logic [32:0] s;
    logic        v;
    ob = rsub ? ~rb : rb;
    s  = {1'b0, ra} + {1'b0, ob} + {32'd0, (rsub | rcin)};
    v  = (ra[31] == ob[31]) && (s[31] != ra[31]);
    return {s[31:0], s[32], v, (s[31:0] == 32'd0)};
  endfunction

  task automatic step();
    logic        acc;
    logic        drn;
    logic [34:0] e;
    #1;
    if (hold_q)
      chk("hold", {out_valid, sum, cout, ovf, zero},
          {1'b1, hold_v});
    acc = in_valid & in_ready;
    drn = out_valid & out_ready;
    if (drn) begin
      chk("pending", (exq.size() > 0), 1);
      if (exq.size() > 0) begin
        e = exq.pop_front();
        chk("res", {sum, cout, ovf, zero}, e);
      end
    end
    if (acc) begin
      exq.push_back(ref_op(a, b, cin, sub));
      acc_cnt++;
    end
    hold_q = out_valid & ~out_ready;
    hold_v = {sum, cout, ovf, zero};
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rnd_in();
    a   = $urandom;
    b   = $urandom;
    cin = 1'($urandom_range(1));
    sub = 1'($urandom_range(1));
  endtask

  task automatic op_dir(input logic [31:0] da, input logic [31:0] db,
                        input logic dcin, input logic dsub,
                        input logic [31:0] es, input logic ec,
                        input logic eo, input logic ez);
    a = da; b = db; cin = dcin; sub = dsub;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("lat1", out_valid, 0);
    step();
    chk("lat2", out_valid, 1);
    chk("dsum", sum, es);
    chk("dflags", {cout, ovf, zero}, {ec, eo, ez});
    step();
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && exq.size() > 0; k++) step();
    chk("drained", exq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    // reset with in_valid asserted
    in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_none", out_valid, 0);
      step();
    end

    op_dir(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0,
           32'h0000_0000, 1'b1, 1'b0, 1'b1);
    op_dir(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
           32'h8000_0000, 1'b0, 1'b1, 1'b0);
    op_dir(32'd5, 32'd7, 1'b0, 1'b1,
           32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    op_dir(32'd7, 32'd5, 1'b1, 1'b1,
           32'h0000_0002, 1'b1, 1'b0, 1'b0);
    op_dir(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0,
           32'h0000_0000, 1'b1, 1'b0, 1'b1);

    // back-to-back random, full throughput
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rnd_in();
      in_valid = 1'b1;
      chk("tput_rdy", in_ready, 1);
      if (i >= 2) chk("tput_ov", out_valid, 1);
      step();
    end
    in_valid = 1'b0;
    drain(10);

    // stall: only two ops fit
    out_ready = 1'b0;
    base = acc_cnt;
    for (int i = 0; i < 5; i++) begin
      rnd_in();
      in_valid = 1'b1;
      step();
    end
    chk("stall_acc", acc_cnt - base, 2);
    chk("stall_rdy", in_ready, 0);
    chk("stall_ov", out_valid, 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain(6);

    // random out_ready with random in_valid
    for (int i = 0; i < 200; i++) begin
      rnd_in();
      in_valid  = 1'($urandom_range(1));
      out_ready = 1'($urandom_range(1));
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain(10);

    // reset in the middle of a stall
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rnd_in();
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("mid_full", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_rdy", in_ready, 1);
    chk("mid_rst_sum", sum, 0);
    exq.delete();
    hold_q = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("no_replay", out_valid, 0);
      step();
    end
    op_dir(32'h1234_5678, 32'h0000_0008, 1'b0, 1'b1,
           32'h1234_5670, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
